spi_flash_rd_ctrl: RTL

- Synthesizable SPI flash read master; drives csb/sck/io0-3 of the board flash (pins, or the flash sim model in bench).
- Converts a word-read request (24-bit byte address, word count) into a single-SPI 0x03 read or a quad 0xEB read, and returns little-endian 32-bit words over a valid/ready stream.
- Sits between the FPGA-side boot/loader logic and the flash pins.
- Never enters XIP continuous mode: the mode byte is always 0x00.

---
 rtl/spi_flash_rd_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_rd_ctrl.sv
// SPI flash read master: turns word-read requests into 0x03 single or 0xEB quad
// reads and streams little-endian 32-bit words back over a valid/ready port.
module spi_flash_rd_ctrl #(
    parameter int CLK_DIV      = 2,
    parameter int CSB_HIGH     = 4,
    parameter int DUMMY_CYCLES = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic        req_quad,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        rd_last,
    input  logic        rd_ready,
    output logic        busy,
    output logic        spi_csb,
    output logic        spi_sck,
    output logic [3:0]  spi_io_out,
    output logic [3:0]  spi_io_oe,
    input  logic [3:0]  spi_io_in
);

    typedef enum logic [3:0] {
        S_IDLE, S_CSLO, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_STALL, S_CSEND, S_CSHI
    } state_t;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] CSH_LAST   = 8'(CSB_HIGH - 1);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    state_t      state;
    logic [7:0]  div_cnt;
    logic [7:0]  bit_cnt;
    logic [8:0]  words_left;
    logic [31:0] tx_shift;
    logic [7:0]  rx_byte;
    logic [31:0] rx_word;
    logic        quad;

    logic        tick;
    logic        out_free;
    logic        last_word;
    logic        phase_done;
    logic        byte_done;
    logic [7:0]  phase_last;
    logic [31:0] tx_next;
    logic [7:0]  rx_byte_next;

    assign tick         = (div_cnt == DIV_LAST);
    assign out_free     = !rd_valid || rd_ready;
    assign last_word    = (words_left == 9'd1);
    assign phase_done   = (bit_cnt == phase_last);
    assign byte_done    = quad ? bit_cnt[0] : (bit_cnt[2:0] == 3'd7);
    assign tx_next      = (quad && state == S_ADDR) ? {tx_shift[27:0], 4'b0000}
                                                    : {tx_shift[30:0], 1'b0};
    assign rx_byte_next = quad ? {rx_byte[3:0], spi_io_in} : {rx_byte[6:0], spi_io_in[1]};

    // Number of SCK cycles (minus one) in the current phase; DATA counts per word.
    always_comb begin
        phase_last = 8'd0;
        case (state)
            S_CMD:   phase_last = 8'd7;
            S_ADDR:  phase_last = quad ? 8'd5 : 8'd23;
            S_MODE:  phase_last = 8'd1;
            S_DUMMY: phase_last = DUMMY_LAST;
            S_DATA:  phase_last = quad ? 8'd7 : 8'd31;
            default: phase_last = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            div_cnt    <= 8'd0;
            bit_cnt    <= 8'd0;
            words_left <= 9'd0;
            tx_shift   <= 32'd0;
            rx_byte    <= 8'd0;
            rx_word    <= 32'd0;
            quad       <= 1'b0;
            req_ready  <= 1'b0;
            busy       <= 1'b0;
            rd_data    <= 32'd0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            spi_csb    <= 1'b1;
            spi_sck    <= 1'b0;
            spi_io_out <= 4'b0000;
            spi_io_oe  <= 4'b0000;
        end else begin
            if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        quad       <= req_quad;
                        tx_shift   <= {(req_quad ? 8'hEB : 8'h03), req_addr};
                        words_left <= {(req_len == 8'd0), req_len};
                        state      <= S_CSLO;
                    end
                end

                S_CSLO: begin
                    spi_csb    <= 1'b0;
                    spi_io_oe  <= 4'b0001;
                    spi_io_out <= {3'b000, tx_shift[31]};
                    div_cnt    <= 8'd0;
                    bit_cnt    <= 8'd0;
                    state      <= S_CMD;
                end

                S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA: begin
                    if (!tick) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else if (!spi_sck) begin
                        div_cnt <= 8'd0;
                        spi_sck <= 1'b1;
                        if (state == S_DATA) begin
                            rx_byte <= rx_byte_next;
                            if (byte_done)
                                rx_word <= {rx_byte_next, rx_word[31:8]};
                        end
                    end else begin
                        // Falling edge: the only point where pin drive values move.
                        div_cnt  <= 8'd0;
                        spi_sck  <= 1'b0;
                        tx_shift <= tx_next;
                        if (!phase_done) begin
                            bit_cnt <= bit_cnt + 8'd1;
                            if (state == S_CMD)
                                spi_io_out <= {3'b000, tx_next[31]};
                            else if (state == S_ADDR)
                                spi_io_out <= quad ? tx_next[31:28] : {3'b000, tx_next[31]};
                        end else begin
                            bit_cnt <= 8'd0;
                            case (state)
                                S_CMD: begin
                                    state <= S_ADDR;
                                    if (quad) begin
                                        spi_io_oe  <= 4'b1111;
                                        spi_io_out <= tx_next[31:28];
                                    end else begin
                                        spi_io_out <= {3'b000, tx_next[31]};
                                    end
                                end
                                S_ADDR: begin
                                    spi_io_out <= 4'b0000;
                                    if (quad) begin
                                        spi_io_oe <= 4'b1111;
                                        state     <= S_MODE;
                                    end else begin
                                        spi_io_oe <= 4'b0001;
                                        state     <= S_DATA;
                                    end
                                end
                                S_MODE: begin
                                    spi_io_oe  <= 4'b0000;
                                    spi_io_out <= 4'b0000;
                                    state      <= S_DUMMY;
                                end
                                S_DUMMY: begin
                                    state <= S_DATA;
                                end
                                default: begin
                                    if (out_free) begin
                                        rd_data    <= rx_word;
                                        rd_valid   <= 1'b1;
                                        rd_last    <= last_word;
                                        words_left <= words_left - 9'd1;
                                        state      <= last_word ? S_CSEND : S_DATA;
                                    end else begin
                                        state <= S_STALL;
                                    end
                                end
                            endcase
                        end
                    end
                end

                // SCK parked low with csb held until the output register frees up.
                S_STALL: begin
                    div_cnt <= 8'd0;
                    if (out_free) begin
                        rd_data    <= rx_word;
                        rd_valid   <= 1'b1;
                        rd_last    <= last_word;
                        words_left <= words_left - 9'd1;
                        state      <= last_word ? S_CSEND : S_DATA;
                    end
                end

                S_CSEND: begin
                    if (tick) begin
                        div_cnt    <= 8'd0;
                        bit_cnt    <= 8'd0;
                        spi_csb    <= 1'b1;
                        spi_io_oe  <= 4'b0000;
                        spi_io_out <= 4'b0000;
                        state      <= S_CSHI;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                S_CSHI: begin
                    if (bit_cnt == CSH_LAST) begin
                        bit_cnt   <= 8'd0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
